// File: rtl/issue_pkg.sv
// ----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the dual-issue scoreboard controller:
//   - instruction field widths and bundle width
//   - packed instruction struct {op, des, src1, src2}
//   - controller FSM state encoding
//   - helpers: bundle -> struct conversion, saturating counter add
// ----------------------------------------------------------------------------
package issue_pkg;

    localparam int OP_W     = 4;
    localparam int DES_W    = 4;
    localparam int SRC_W    = 4;
    localparam int INS_W    = OP_W + DES_W + 2 * SRC_W;
    localparam int REG_NUM  = 2 ** DES_W;
    localparam int WB_PORTS = 2;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [DES_W-1:0] des;
        logic [SRC_W-1:0] src1;
        logic [SRC_W-1:0] src2;
    } ins_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Reinterpret a raw instruction bundle as its fields.
    function automatic ins_t unpack_ins(input logic [INS_W-1:0] raw);
        return ins_t'(raw);
    endfunction

    // Add a small increment to a 32-bit counter, sticking at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] n);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// ----------------------------------------------------------------------------
// scoreboard_bank
// Per-register busy bits for the architectural register file.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : clear every busy bit (overrides set and clear)
//   wb_valid      : per-port writeback strobe
//   wb_addr       : per-port writeback destination (packed, port 0 in LSBs)
//   set_mask      : destinations of instructions issued this cycle
//   busy          : registered scoreboard
//   eb            : effective busy = busy with this cycle's writebacks removed
// ----------------------------------------------------------------------------
module scoreboard_bank
    import issue_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*DES_W-1:0] wb_addr,
    input  logic [REG_NUM-1:0]        set_mask,
    output logic [REG_NUM-1:0]        busy,
    output logic [REG_NUM-1:0]        eb
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [REG_NUM-1:0] clr_mask;
    logic [REG_NUM-1:0] port_mask [WB_PORTS];

    // One-hot decode of each writeback port.
    generate
        for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb_dec
            assign port_mask[gi] = wb_valid[gi]
                                 ? (REG_NUM'(1) << wb_addr[gi*DES_W +: DES_W])
                                 : '0;
        end
    endgenerate

    always_comb begin
        clr_mask = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            clr_mask = clr_mask | port_mask[p];
        end
    end

    assign eb = busy_q & ~clr_mask;

    // Clear first, then set: an instruction issued to a register that is
    // being written back this cycle keeps the register busy.
    assign busy_d = flush ? '0 : (eb | set_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// ----------------------------------------------------------------------------
// issue_scoreboard_ctrl
// In-order dual-issue controller. Each cycle decides which of the two decoded
// slots may issue without RAW/WAW hazards, registers the issued pair and its
// register-file read addresses, and tracks destinations in a busy scoreboard.
// Serializing instructions wait for an empty scoreboard and issue alone;
// a branch flush kills everything in flight.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid[1:0]     slot k holds a decoded instruction
//   in_ins0/in_ins1   {op,des,src1,src2} per slot
//   in_wr_en[1:0]     slot writes des
//   in_rd_en[3:0]     [2k]=src1 used, [2k+1]=src2 used for slot k
//   in_serial[1:0]    slot is serializing
//   in_ready[1:0]     slot consumed this cycle (combinational)
//   iss_ready         downstream can accept
//   iss_valid[1:0]    registered issued slots
//   iss_ins0/iss_ins1 registered issued instructions
//   rf_raddr          registered {s1_src2,s1_src1,s0_src2,s0_src1}
//   wb_valid, wb_addr writebacks clearing the scoreboard
//   flush             branch mispredict
//   busy_vec          current scoreboard
// Optional (macro ISSUE_STATS_EN): stat_issued, stat_raw_stall, stat_drain
// saturating 32-bit counters, cleared by rst only.
// ----------------------------------------------------------------------------
module issue_scoreboard_ctrl
    import issue_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                in_valid,
    input  logic [INS_W-1:0]          in_ins0,
    input  logic [INS_W-1:0]          in_ins1,
    input  logic [1:0]                in_wr_en,
    input  logic [3:0]                in_rd_en,
    input  logic [1:0]                in_serial,
    output logic [1:0]                in_ready,
    input  logic                      iss_ready,
    output logic [1:0]                iss_valid,
    output logic [INS_W-1:0]          iss_ins0,
    output logic [INS_W-1:0]          iss_ins1,
    output logic [4*SRC_W-1:0]        rf_raddr,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*DES_W-1:0] wb_addr,
    input  logic                      flush,
    output logic [REG_NUM-1:0]        busy_vec
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_raw_stall,
    output logic [31:0]               stat_drain
`endif
);

    ins_t               s0;
    ins_t               s1;
    logic [REG_NUM-1:0] eb;
    logic [REG_NUM-1:0] set_mask;
    logic               eb_empty;
    logic               raw0, waw0, raw1, waw1;
    logic               issue0, issue1;

    state_t             state_q;
    logic [1:0]         iss_valid_q;
    ins_t               iss_ins0_q;
    ins_t               iss_ins1_q;
    logic [4*SRC_W-1:0] rf_raddr_q;

    assign s0 = unpack_ins(in_ins0);
    assign s1 = unpack_ins(in_ins1);

    scoreboard_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .set_mask (set_mask),
        .busy     (busy_vec),
        .eb       (eb)
    );

    assign eb_empty = (eb == '0);

    // Slot 0 only sees registers still pending after this cycle's writebacks.
    assign raw0 = (in_rd_en[0] && eb[s0.src1]) || (in_rd_en[1] && eb[s0.src2]);
    assign waw0 = in_wr_en[0] && eb[s0.des];

    // Slot 1 additionally sees slot 0's destination, since they issue together.
    assign raw1 = (in_rd_en[2] && (eb[s1.src1] || (in_wr_en[0] && (s1.src1 == s0.des))))
               || (in_rd_en[3] && (eb[s1.src2] || (in_wr_en[0] && (s1.src2 == s0.des))));
    assign waw1 = in_wr_en[1] && (eb[s1.des] || (in_wr_en[0] && (s1.des == s0.des)));

    always_comb begin
        issue0 = 1'b0;
        issue1 = 1'b0;
        unique case (state_q)
            RUN: begin
                if (in_serial[0]) begin
                    issue0 = in_valid[0] && eb_empty;
                end else begin
                    issue0 = in_valid[0] && !raw0 && !waw0;
                end
                issue1 = issue0 && in_valid[1] && !raw1 && !waw1
                      && !in_serial[0] && !in_serial[1];
            end
            DRAIN: begin
                // Slot 0 is the waiting serial instruction; it goes alone.
                issue0 = in_valid[0] && eb_empty;
            end
            default: begin
                issue0 = 1'b0;
            end
        endcase
        if (rst || flush || !iss_ready) begin
            issue0 = 1'b0;
            issue1 = 1'b0;
        end
    end

    assign in_ready = {issue1, issue0};

    assign set_mask = ((issue0 && in_wr_en[0]) ? (REG_NUM'(1) << s0.des) : '0)
                    | ((issue1 && in_wr_en[1]) ? (REG_NUM'(1) << s1.des) : '0);

    // Controller FSM with registered issue outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            iss_valid_q <= '0;
            iss_ins0_q  <= '0;
            iss_ins1_q  <= '0;
            rf_raddr_q  <= '0;
        end else if (flush) begin
            state_q     <= FLUSH;
            iss_valid_q <= '0;
        end else begin
            unique case (state_q)
                RUN:     if (in_valid[0] && in_serial[0] && !eb_empty) state_q <= DRAIN;
                DRAIN:   if (eb_empty) state_q <= RUN;
                default: state_q <= RUN;
            endcase
            // With downstream stalled the issue registers hold their contents.
            if (iss_ready) begin
                iss_valid_q <= {issue1, issue0};
                if (issue0) begin
                    iss_ins0_q       <= s0;
                    rf_raddr_q[7:0]  <= {s0.src2, s0.src1};
                end
                if (issue1) begin
                    iss_ins1_q       <= s1;
                    rf_raddr_q[15:8] <= {s1.src2, s1.src1};
                end
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_ins0  = iss_ins0_q;
    assign iss_ins1  = iss_ins1_q;
    assign rf_raddr  = rf_raddr_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_raw_stall_q;
    logic [31:0] stat_drain_q;
    logic [1:0]  issue_cnt;
    logic        raw_stall;

    assign issue_cnt = {1'b0, issue0} + {1'b0, issue1};
    assign raw_stall = (state_q == RUN) && !flush && in_valid[0] && !in_serial[0] && raw0;

    // Counters survive a flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q    <= '0;
            stat_raw_stall_q <= '0;
            stat_drain_q     <= '0;
        end else begin
            stat_issued_q    <= sat_add(stat_issued_q, issue_cnt);
            stat_raw_stall_q <= sat_add(stat_raw_stall_q, {1'b0, raw_stall});
            stat_drain_q     <= sat_add(stat_drain_q, {1'b0, (state_q == DRAIN)});
        end
    end

    assign stat_issued    = stat_issued_q;
    assign stat_raw_stall = stat_raw_stall_q;
    assign stat_drain     = stat_drain_q;
`endif

endmodule
